seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the board's common-anode 7-segment display bank. It holds a display word and a decimal-point mask, and steps a digit index across the digits. Each digit's nibble is presented to the `segments` hex decoder, and the matching anode is driven with a ghost-suppression guard interval. Host writes go through a valid/ready handshake into a one-entry pending buffer. The buffer is committed only at a frame boundary, so a frame never shows a torn value.

## Interface
Parameters:
- `NDIGITS`, 4: number of digits scanned; the display word is 4*NDIGITS bits.
- `DIV`, 50000: clock cycles per digit slot; must be at least 2.
- `GUARD`, 500: cycles at the start of each slot with all anodes off; must satisfy 1 <= GUARD < DIV.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `wr_valid`, input, 1: host write request.
- `wr_ready`, output, 1: pending buffer empty; a write is accepted when `wr_valid` and `wr_ready` are both high.
- `wr_data`, input, 4*NDIGITS: new display word; nibble i drives digit i, and digit 0 is the least significant.
- `wr_dp`, input, NDIGITS: new decimal-point mask; 1 lights the point on that digit.
- `lzb_en`, input, 1: leading-zero blanking enable; sampled live, not buffered.
- `digit_num`, output, 4: nibble of the current digit, feeding the `segments` decoder input `number`.
- `an_n`, output, NDIGITS: anode enables, active-low, at most one bit low at a time.
- `dp_n`, output, 1: decimal point, active-low.
- `frame_tick`, output, 1: one-cycle pulse marking the start of a frame.

## Operation
- State: slot counter `cnt` (0..DIV-1), digit index `idx` (0..NDIGITS-1), phase (GUARD while cnt < GUARD, else ON), committed `disp` and `dp`, pending `pend_data`, `pend_dp`, and the flag `pend_full`.
- The counter advances every cycle. When cnt == DIV-1:
  - next cycle cnt = 0;
  - idx wraps from NDIGITS-1 to 0, otherwise increments.
- Frame boundary: the edge on which idx wraps NDIGITS-1 to 0.
  - If pend_full, then disp <= pend_data, dp <= pend_dp, and pend_full <= 0.
  - frame_tick is high for exactly the first cycle of the new frame (cnt == 0, idx == 0).
- Write accept: when wr_valid && wr_ready, capture wr_data and wr_dp into the pending buffer and set pend_full.
  - wr_ready = !pend_full, so a write while full is ignored.
- Write on the commit edge:
  - If pend_full was 1, the commit happens and the write is not accepted, because wr_ready was 0.
  - If pend_full was 0, the write fills the buffer and is committed at the next boundary.
- Display outputs are driven from registered state only; there is no combinational path from any input.
  - digit_num = disp nibble idx.
  - an_n[idx] = 0 only in the ON phase and when the digit is not blanked; every other bit of an_n is 1.
  - dp_n = !(dp[idx] && the anode is on).
- Leading-zero blanking: with lzb_en = 1, digit i > 0 is blanked when nibbles i..NDIGITS-1 of disp are all 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps all anodes high and dp_n = 1.
- Reset (asynchronous, rst_n low): cnt = 0, idx = 0, disp = 0, dp = 0, pend_full = 0.
  - Outputs during reset: wr_ready = 1, an_n = all 1, digit_num = 0, dp_n = 1, frame_tick = 0.
  - A reset mid-frame or mid-write discards the pending data.
  - After release, the first cycle is slot 0 in GUARD phase; no frame_tick is issued for this initial frame.

## Timing
- The digit period is DIV cycles, and the frame period is NDIGITS*DIV cycles.
- Anode on-time per slot is DIV-GUARD cycles, beginning at cnt == GUARD.
- digit_num changes on the slot edge. The decoder has GUARD cycles of settling before the anode turns on.
- Write to display latency:
  - at least 1 cycle;
  - at most NDIGITS*DIV cycles, until the next frame boundary;
  - plus GUARD cycles before the new digit 0 is lit.
- wr_ready falls the cycle after acceptance and rises the cycle after commit.
- The counter width is enough to hold DIV-1, and arithmetic wraps only through the explicit reset to 0.

## Test plan
Bench parameters: NDIGITS=4, DIV=8, GUARD=2.
- Reset: hold rst_n low for 3 cycles, then release. Expect an_n = 4'b1111 and wr_ready = 1 during reset; the first frame_tick at cycle 32 after release; idx visiting 0,1,2,3 every 8 cycles.
- Write and commit: write 16'h12A4 with dp 4'b0010. Expect wr_ready to drop the next cycle and the display to stay 0 until the boundary. After the boundary, digit_num reads 4,A,2,1 per slot; an_n goes 1110/1101/1011/0111 low from cnt 2 to 7 only; dp_n = 0 only on digit 1.
- Back-to-back writes: write 16'h1111, then 16'h2222 while wr_ready = 0. Expect the second write ignored and the committed value 16'h1111.
- Write on the boundary cycle with the buffer empty: write 16'h5555 on the wrap edge. Expect it to be pending and shown only after the following frame_tick.
- Leading-zero blanking: with disp = 16'h0070 and lzb_en = 1, expect digits 3 and 2 blanked (an_n = 1111 in their slots) while digits 1 and 0 show 7 and 0. With disp = 16'h0000, only digit 0 lights, showing 0.
- Reset mid-write: accept 16'hBEEF, assert rst_n low mid-frame, then release. Expect disp = 0, wr_ready = 1, and 16'hBEEF never displayed.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl_if
// Brief    : Host write handshake and display-drive bundle for seg_scan_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if #(
    parameter int NDIGITS = 4
);
    logic                   wr_valid;
    logic                   wr_ready;
    logic [4*NDIGITS-1:0]   wr_data;
    logic [NDIGITS-1:0]     wr_dp;
    logic                   lzb_en;
    logic [3:0]             digit_num;
    logic [NDIGITS-1:0]     an_n;
    logic                   dp_n;
    logic                   frame_tick;

    modport master (
        output wr_valid, wr_data, wr_dp, lzb_en,
        input  wr_ready, digit_num, an_n, dp_n, frame_tick
    );

    modport slave (
        input  wr_valid, wr_data, wr_dp, lzb_en,
        output wr_ready, digit_num, an_n, dp_n, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Multiplexed 7-segment scan controller with frame-aligned commit.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NDIGITS = 4,
    parameter int DIV     = 50000,
    parameter int GUARD   = 500
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    seg_scan_ctrl_if.slave     bus
);
    localparam int c_CW = $clog2(DIV);
    localparam int c_IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int c_W  = 4 * NDIGITS;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DIV - 1);
    localparam logic [c_CW-1:0] c_GUARD   = c_CW'(GUARD);
    localparam logic [c_IW-1:0] c_IDX_MAX = c_IW'(NDIGITS - 1);

    logic [c_CW-1:0]    r_cnt;
    logic [c_IW-1:0]    r_idx;
    logic [c_W-1:0]     r_disp;
    logic [NDIGITS-1:0] r_dp;
    logic [c_W-1:0]     r_pend_data;
    logic [NDIGITS-1:0] r_pend_dp;
    logic               r_pend_full;
    logic               r_frame_tick;
    logic               r_lzb;

    logic               w_slot_end;
    logic               w_wrap;
    logic               w_accept;
    logic [NDIGITS-1:0] w_blank;
    logic               w_lit;

    assign w_slot_end = (r_cnt == c_CNT_MAX);
    assign w_wrap     = w_slot_end && (r_idx == c_IDX_MAX);
    assign w_accept   = bus.wr_valid && !r_pend_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_disp       <= '0;
            r_dp         <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_full  <= 1'b0;
            r_frame_tick <= 1'b0;
            r_lzb        <= 1'b0;
        end else begin
            r_lzb        <= bus.lzb_en;
            r_frame_tick <= w_wrap;
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Accept and commit are mutually exclusive: accept needs an empty buffer.
            if (w_accept) begin
                r_pend_data <= bus.wr_data;
                r_pend_dp   <= bus.wr_dp;
                r_pend_full <= 1'b1;
            end else if (w_wrap && r_pend_full) begin
                r_disp      <= r_pend_data;
                r_dp        <= r_pend_dp;
                r_pend_full <= 1'b0;
            end
        end
    end

    // A digit is blanked when it and every more-significant nibble are zero.
    for (genvar i = 0; i < NDIGITS; i++) begin : g_blank
        if (i == 0) begin : g_lsd
            assign w_blank[i] = 1'b0;
        end else begin : g_upper
            assign w_blank[i] = r_lzb && (r_disp[c_W-1:4*i] == '0);
        end
    end

    assign w_lit = (r_cnt >= c_GUARD) && !w_blank[r_idx];

    for (genvar i = 0; i < NDIGITS; i++) begin : g_an
        assign bus.an_n[i] = !(w_lit && (r_idx == c_IW'(i)));
    end

    assign bus.digit_num  = r_disp[{r_idx, 2'b00} +: 4];
    assign bus.dp_n       = !(r_dp[r_idx] && w_lit);
    assign bus.wr_ready   = !r_pend_full;
    assign bus.frame_tick = r_frame_tick;
endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Scoreboard bench for seg_scan_ctrl (NDIGITS=4, DIV=8, GUARD=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;
    localparam int c_ND = 4;
    localparam int c_DIV = 8;
    localparam int c_GUARD = 2;
    localparam int c_FRAME = c_ND * c_DIV;

    typedef struct {
        logic [15:0] w;
        logic [3:0]  dp;
        int          acc;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    seg_scan_ctrl_if #(.NDIGITS(c_ND)) bus();

    seg_scan_ctrl #(.NDIGITS(c_ND), .DIV(c_DIV), .GUARD(c_GUARD)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          phase = 0;
    ent_t        q[$];
    logic [15:0] cur_w = '0;
    logic [3:0]  cur_dp = '0;
    logic [3:0]  cap_an [c_FRAME];
    logic [3:0]  cap_num[c_FRAME];
    logic        cap_dpn[c_FRAME];

    function automatic logic [3:0] exp_an(logic [15:0] w, logic lzb, int k);
        int s = k / c_DIV;
        int c = k % c_DIV;
        logic [15:0] hi = w >> (4 * s);
        logic blank = lzb && (s > 0) && (hi == 16'h0);
        if (c >= c_GUARD && !blank) return ~(4'b0001 << s);
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_num(logic [15:0] w, int k);
        logic [15:0] t = w >> (4 * (k / c_DIV));
        return t[3:0];
    endfunction

    function automatic logic exp_dpn(logic [15:0] w, logic [3:0] dp, logic lzb, int k);
        logic lit = (exp_an(w, lzb, k) != 4'hF);
        return !(dp[k / c_DIV] && lit);
    endfunction

    // One clock step; also applies the model's frame-boundary commit.
    task automatic tick();
        ent_t e;
        @(negedge clk);
        cyc++;
        phase = (phase + 1) % c_FRAME;
        if (phase == 0 && q.size() > 0 && q[0].acc < cyc) begin
            e = q.pop_front();
            cur_w = e.w;
            cur_dp = e.dp;
        end
    endtask

    task automatic goto_phase(int p);
        while (phase != p) tick();
    endtask

    task automatic do_write(logic [15:0] w, logic [3:0] dp, output logic acc);
        ent_t e;
        bus.wr_valid = 1'b1;
        bus.wr_data  = w;
        bus.wr_dp    = dp;
        acc = bus.wr_ready;
        if (acc) begin
            e.w = w; e.dp = dp; e.acc = cyc + 1;
            q.push_back(e);
        end
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic capture_frame();
        for (int k = 0; k < c_FRAME; k++) begin
            cap_an[k]  = bus.an_n;
            cap_num[k] = bus.digit_num;
            cap_dpn[k] = bus.dp_n;
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (3) begin
            n_chk += 3;
            if (bus.an_n !== 4'hF) begin n_err++; $display("FAIL rst_an got %b exp 1111", bus.an_n); end
            if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b exp 1", bus.wr_ready); end
            if (bus.frame_tick !== 1'b0 || bus.dp_n !== 1'b1 || bus.digit_num !== 4'h0) begin
                n_err++; $display("FAIL rst_out got tick %b dp_n %b num %h exp 0 1 0", bus.frame_tick, bus.dp_n, bus.digit_num);
            end
            tick();
        end
        rst_n = 1'b1;
        for (int k = 0; k < c_FRAME; k++) begin
            n_chk += 2;
            if (bus.an_n !== exp_an(16'h0, 1'b0, k)) begin n_err++; $display("FAIL init_an k=%0d got %b exp %b", k, bus.an_n, exp_an(16'h0, 1'b0, k)); end
            if (bus.frame_tick !== 1'b0) begin n_err++; $display("FAIL init_tick k=%0d got 1 exp 0", k); end
            tick();
        end
        n_chk++;
        if (bus.frame_tick !== 1'b1) begin n_err++; $display("FAIL first_tick at 32 got %b exp 1", bus.frame_tick); end
        phase = 0;
    endtask

    task automatic test_write_commit();
        logic acc;
        logic [15:0] ew;
        logic [3:0] edp;
        goto_phase(5);
        do_write(16'h12A4, 4'b0010, acc);
        n_chk += 2;
        if (acc !== 1'b1) begin n_err++; $display("FAIL wc_accept got %b exp 1", acc); end
        if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL wc_ready_drop got %b exp 0", bus.wr_ready); end
        while (phase != 0) begin
            n_chk++;
            if (bus.digit_num !== 4'h0 || bus.an_n !== exp_an(16'h0, 1'b0, phase)) begin
                n_err++; $display("FAIL wc_hold ph=%0d got num %h an %b exp num 0 an %b", phase, bus.digit_num, bus.an_n, exp_an(16'h0, 1'b0, phase));
            end
            tick();
        end
        n_chk += 2;
        if (bus.frame_tick !== 1'b1) begin n_err++; $display("FAIL wc_tick got %b exp 1", bus.frame_tick); end
        if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL wc_ready_rise got %b exp 1", bus.wr_ready); end
        ew = cur_w; edp = cur_dp;
        capture_frame();
        for (int k = 0; k < c_FRAME; k++) begin
            n_chk += 3;
            if (cap_an[k] !== exp_an(ew, 1'b0, k)) begin n_err++; $display("FAIL wc_an k=%0d got %b exp %b", k, cap_an[k], exp_an(ew, 1'b0, k)); end
            if (cap_num[k] !== exp_num(ew, k)) begin n_err++; $display("FAIL wc_num k=%0d got %h exp %h", k, cap_num[k], exp_num(ew, k)); end
            if (cap_dpn[k] !== exp_dpn(ew, edp, 1'b0, k)) begin n_err++; $display("FAIL wc_dpn k=%0d got %b exp %b", k, cap_dpn[k], exp_dpn(ew, edp, 1'b0, k)); end
        end
        n_chk += 3;
        if (cap_num[8] !== 4'hA) begin n_err++; $display("FAIL wc_digit1 got %h exp a", cap_num[8]); end
        if (cap_an[13] !== 4'b1101 || cap_dpn[13] !== 1'b0) begin n_err++; $display("FAIL wc_dp1 got an %b dp_n %b exp 1101 0", cap_an[13], cap_dpn[13]); end
        if (cap_an[25] !== 4'hF) begin n_err++; $display("FAIL wc_guard got %b exp 1111", cap_an[25]); end
    endtask

    task automatic test_back_to_back();
        logic acc1, acc2;
        logic [15:0] ew;
        logic [3:0] edp;
        goto_phase(3);
        do_write(16'h1111, 4'b0001, acc1);
        do_write(16'h2222, 4'b1000, acc2);
        n_chk += 2;
        if (acc1 !== 1'b1) begin n_err++; $display("FAIL b2b_first got %b exp 1", acc1); end
        if (acc2 !== 1'b0) begin n_err++; $display("FAIL b2b_second got %b exp 0", acc2); end
        goto_phase(0);
        ew = cur_w; edp = cur_dp;
        capture_frame();
        for (int k = 0; k < c_FRAME; k++) begin
            n_chk += 3;
            if (cap_an[k] !== exp_an(ew, 1'b0, k)) begin n_err++; $display("FAIL b2b_an k=%0d got %b exp %b", k, cap_an[k], exp_an(ew, 1'b0, k)); end
            if (cap_num[k] !== exp_num(ew, k)) begin n_err++; $display("FAIL b2b_num k=%0d got %h exp %h", k, cap_num[k], exp_num(ew, k)); end
            if (cap_dpn[k] !== exp_dpn(ew, edp, 1'b0, k)) begin n_err++; $display("FAIL b2b_dpn k=%0d got %b exp %b", k, cap_dpn[k], exp_dpn(ew, edp, 1'b0, k)); end
        end
        n_chk++;
        if (cap_num[28] !== 4'h1) begin n_err++; $display("FAIL b2b_value got %h exp 1", cap_num[28]); end
    endtask

    task automatic test_boundary_write();
        logic acc;
        logic [15:0] ew;
        logic [3:0] edp;
        goto_phase(c_FRAME - 1);
        do_write(16'h5555, 4'b0100, acc);
        n_chk += 3;
        if (acc !== 1'b1) begin n_err++; $display("FAIL bnd_accept got %b exp 1", acc); end
        if (bus.frame_tick !== 1'b1) begin n_err++; $display("FAIL bnd_tick got %b exp 1", bus.frame_tick); end
        if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL bnd_pending got %b exp 0", bus.wr_ready); end
        repeat (2) begin
            ew = cur_w; edp = cur_dp;
            capture_frame();
            for (int k = 0; k < c_FRAME; k++) begin
                n_chk += 3;
                if (cap_an[k] !== exp_an(ew, 1'b0, k)) begin n_err++; $display("FAIL bnd_an k=%0d got %b exp %b", k, cap_an[k], exp_an(ew, 1'b0, k)); end
                if (cap_num[k] !== exp_num(ew, k)) begin n_err++; $display("FAIL bnd_num k=%0d got %h exp %h", k, cap_num[k], exp_num(ew, k)); end
                if (cap_dpn[k] !== exp_dpn(ew, edp, 1'b0, k)) begin n_err++; $display("FAIL bnd_dpn k=%0d got %b exp %b", k, cap_dpn[k], exp_dpn(ew, edp, 1'b0, k)); end
            end
        end
        n_chk++;
        if (cap_num[20] !== 4'h5) begin n_err++; $display("FAIL bnd_shown got %h exp 5", cap_num[20]); end
    endtask

    task automatic test_lzb();
        logic acc;
        logic [15:0] ew;
        logic [3:0] edp;
        bus.lzb_en = 1'b1;
        foreach (cap_an[j]) cap_an[j] = 4'h0;
        for (int pass = 0; pass < 2; pass++) begin
            goto_phase(2);
            do_write(pass == 0 ? 16'h0070 : 16'h0000, 4'b0000, acc);
            goto_phase(0);
            ew = cur_w; edp = cur_dp;
            capture_frame();
            for (int k = 0; k < c_FRAME; k++) begin
                n_chk += 3;
                if (cap_an[k] !== exp_an(ew, 1'b1, k)) begin n_err++; $display("FAIL lzb_an k=%0d got %b exp %b", k, cap_an[k], exp_an(ew, 1'b1, k)); end
                if (cap_num[k] !== exp_num(ew, k)) begin n_err++; $display("FAIL lzb_num k=%0d got %h exp %h", k, cap_num[k], exp_num(ew, k)); end
                if (cap_dpn[k] !== exp_dpn(ew, edp, 1'b1, k)) begin n_err++; $display("FAIL lzb_dpn k=%0d got %b exp %b", k, cap_dpn[k], exp_dpn(ew, edp, 1'b1, k)); end
            end
            n_chk += 3;
            if (cap_an[28] !== 4'hF || cap_an[20] !== 4'hF) begin n_err++; $display("FAIL lzb_blank32 got %b %b exp 1111 1111", cap_an[28], cap_an[20]); end
            if (cap_an[4] !== 4'b1110 || cap_num[4] !== 4'h0) begin n_err++; $display("FAIL lzb_digit0 got %b %h exp 1110 0", cap_an[4], cap_num[4]); end
            if (pass == 0 && (cap_an[12] !== 4'b1101 || cap_num[12] !== 4'h7)) begin
                n_err++; $display("FAIL lzb_digit1 got %b %h exp 1101 7", cap_an[12], cap_num[12]);
            end else if (pass == 1 && cap_an[12] !== 4'hF) begin
                n_err++; $display("FAIL lzb_zero_d1 got %b exp 1111", cap_an[12]);
            end
        end
        bus.lzb_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic acc;
        goto_phase(8);
        do_write(16'hBEEF, 4'b1111, acc);
        n_chk++;
        if (acc !== 1'b1) begin n_err++; $display("FAIL mid_accept got %b exp 1", acc); end
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        q.delete();
        cur_w = '0;
        cur_dp = '0;
        n_chk += 2;
        if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got %b exp 1", bus.wr_ready); end
        if (bus.an_n !== 4'hF) begin n_err++; $display("FAIL mid_an got %b exp 1111", bus.an_n); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < c_FRAME; k++) begin
            n_chk++;
            if (bus.frame_tick !== 1'b0 || bus.digit_num !== 4'h0 || bus.an_n !== exp_an(16'h0, 1'b0, k)) begin
                n_err++; $display("FAIL mid_post k=%0d got tick %b num %h an %b exp 0 0 %b", k, bus.frame_tick, bus.digit_num, bus.an_n, exp_an(16'h0, 1'b0, k));
            end
            tick();
        end
        phase = 0;
        n_chk += 2;
        if (bus.frame_tick !== 1'b1) begin n_err++; $display("FAIL mid_tick got %b exp 1", bus.frame_tick); end
        if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_after got %b exp 1", bus.wr_ready); end
        capture_frame();
        for (int k = 0; k < c_FRAME; k++) begin
            n_chk++;
            if (cap_num[k] !== exp_num(cur_w, k) || cap_dpn[k] !== 1'b1) begin
                n_err++; $display("FAIL mid_frame k=%0d got num %h dp_n %b exp 0 1", k, cap_num[k], cap_dpn[k]);
            end
        end
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_dp    = '0;
        bus.lzb_en   = 1'b0;
        test_reset();
        test_write_commit();
        test_back_to_back();
        test_boundary_write();
        test_lzb();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
